mem_response: RTL and testbench

Tracks every main-memory read issued by the memory control stage and, a fixed read latency later, routes the returned word to its destination. Destinations are the conveyor, the data stack, or one of the four DC value registers. The block also keeps the four DC value registers coherent with memory writes: it snoops every write against the current DC addresses and against reads still in flight. It sits directly downstream of the memory control stage and beside the main memory port, consuming that stage's `reload`/`choice`/`*_memload`/`write_*` outputs.

---
 rtl/mem_response_if.sv | 37 +++
 rtl/mem_response.sv | 137 +++++++++++++
 tb/tb_mem_response.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_response_if.sv
// Bus between the memory control stage / main memory port and mem_response.
// Strobes are single-cycle qualifiers with no backpressure.
interface mem_response_if #(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32
);
    logic                            conveyor_memload;
    logic                            dstack_memload;
    logic                            reload;
    logic [1:0]                      choice;
    logic [MAIN_ADDR_WIDTH-1:0]      read_address;
    logic                            write_out;
    logic [MAIN_ADDR_WIDTH-1:0]      write_address;
    logic [WORD_WIDTH-1:0]           write_value;
    logic [3:0][MAIN_ADDR_WIDTH-1:0] dcs;
    logic [WORD_WIDTH-1:0]           mem_read_value;
    logic                            conveyor_valid;
    logic [WORD_WIDTH-1:0]           conveyor_value;
    logic                            dstack_valid;
    logic [WORD_WIDTH-1:0]           dstack_value;
    logic [3:0][WORD_WIDTH-1:0]      dc_vals;
    logic [3:0]                      dc_pending;

    modport master (
        output conveyor_memload, dstack_memload, reload, choice, read_address,
               write_out, write_address, write_value, dcs, mem_read_value,
        input  conveyor_valid, conveyor_value, dstack_valid, dstack_value,
               dc_vals, dc_pending
    );

    modport slave (
        input  conveyor_memload, dstack_memload, reload, choice, read_address,
               write_out, write_address, write_value, dcs, mem_read_value,
        output conveyor_valid, conveyor_value, dstack_valid, dstack_value,
               dc_vals, dc_pending
    );
endinterface

// File: rtl/mem_response.sv
// Tracks in-flight main-memory reads, routes returned words to conveyor,
// data stack or DC value registers, and keeps DC values coherent with writes.
module mem_response #(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int READ_LATENCY    = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_response_if.slave bus
);
    localparam logic [1:0] DEST_CONV   = 2'd0;
    localparam logic [1:0] DEST_DSTACK = 2'd1;
    localparam logic [1:0] DEST_DC     = 2'd2;

    typedef struct packed {
        logic                       valid;
        logic [1:0]                 dest;
        logic [1:0]                 idx;
        logic [MAIN_ADDR_WIDTH-1:0] addr;
        logic                       fwd;
        logic [WORD_WIDTH-1:0]      fwd_value;
    } entry_t;

    entry_t                     pipe_q [READ_LATENCY];
    entry_t                     pipe_d [READ_LATENCY];
    entry_t                     issue_e;
    entry_t                     last_e;
    logic [WORD_WIDTH-1:0]      ret_data;
    logic                       conv_valid_q, conv_valid_d;
    logic [WORD_WIDTH-1:0]      conv_value_q, conv_value_d;
    logic                       dstack_valid_q, dstack_valid_d;
    logic [WORD_WIDTH-1:0]      dstack_value_q, dstack_value_d;
    logic [3:0][WORD_WIDTH-1:0] dc_vals_q, dc_vals_d;
    logic [3:0]                 dc_pending;

    // A write to an in-flight address is newer than what memory will return.
    function automatic entry_t snoop(input entry_t e, input logic wr,
                                     input logic [MAIN_ADDR_WIDTH-1:0] wa,
                                     input logic [WORD_WIDTH-1:0] wv);
        entry_t r;
        r = e;
        if (e.valid && wr && (e.addr == wa)) begin
            r.fwd       = 1'b1;
            r.fwd_value = wv;
        end
        return r;
    endfunction

    always_comb begin
        issue_e = '0;
        if (bus.reload || bus.dstack_memload || bus.conveyor_memload) begin
            issue_e.valid = 1'b1;
            issue_e.addr  = bus.read_address;
            if (bus.reload) begin
                issue_e.dest = DEST_DC;
                issue_e.idx  = bus.choice;
            end else if (bus.dstack_memload) begin
                issue_e.dest = DEST_DSTACK;
            end else begin
                issue_e.dest = DEST_CONV;
            end
        end
        issue_e = snoop(issue_e, bus.write_out, bus.write_address, bus.write_value);
    end

    always_comb begin
        pipe_d[0] = issue_e;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_d[k] = snoop(pipe_q[k-1], bus.write_out, bus.write_address, bus.write_value);
        end
    end

    assign last_e = pipe_q[READ_LATENCY-1];

    always_comb begin
        ret_data = last_e.fwd ? last_e.fwd_value : bus.mem_read_value;
        if (bus.write_out && (bus.write_address == last_e.addr)) begin
            ret_data = bus.write_value;
        end
    end

    always_comb begin
        conv_valid_d   = last_e.valid && (last_e.dest == DEST_CONV);
        dstack_valid_d = last_e.valid && (last_e.dest == DEST_DSTACK);
        conv_value_d   = conv_valid_d ? ret_data : conv_value_q;
        dstack_value_d = dstack_valid_d ? ret_data : dstack_value_q;
        dc_vals_d      = dc_vals_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.write_out && (bus.write_address == bus.dcs[i])) begin
                dc_vals_d[i] = bus.write_value;
            end
        end
        // A returning reload overrides a same-cycle snoop of the same register.
        if (last_e.valid && (last_e.dest == DEST_DC)) begin
            dc_vals_d[last_e.idx] = ret_data;
        end
    end

    always_comb begin
        dc_pending = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            if (pipe_q[k].valid && (pipe_q[k].dest == DEST_DC)) begin
                dc_pending[pipe_q[k].idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
            conv_valid_q   <= 1'b0;
            conv_value_q   <= '0;
            dstack_valid_q <= 1'b0;
            dstack_value_q <= '0;
            dc_vals_q      <= '0;
        end else begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
            conv_valid_q   <= conv_valid_d;
            conv_value_q   <= conv_value_d;
            dstack_valid_q <= dstack_valid_d;
            dstack_value_q <= dstack_value_d;
            dc_vals_q      <= dc_vals_d;
        end
    end

    assign bus.conveyor_valid = conv_valid_q;
    assign bus.conveyor_value = conv_value_q;
    assign bus.dstack_valid   = dstack_valid_q;
    assign bus.dstack_value   = dstack_value_q;
    assign bus.dc_vals        = dc_vals_q;
    assign bus.dc_pending     = dc_pending;
endmodule

// File: tb/tb_mem_response.sv
// Bench for mem_response: directed vector table, reset-in-flight sequence and
// random traffic, all checked against a memory-level reference model.
module tb_mem_response;
    localparam int AW = 16;
    localparam int WW = 32;
    localparam int L  = 2;
    localparam logic [1:0] D_CONV   = 2'd0;
    localparam logic [1:0] D_DSTACK = 2'd1;
    localparam logic [1:0] D_DC     = 2'd2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_response_if #(.MAIN_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus();

    mem_response #(.MAIN_ADDR_WIDTH(AW), .WORD_WIDTH(WW), .READ_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          reload;
        logic [1:0]    choice;
        logic          dstack;
        logic          conv;
        logic [AW-1:0] raddr;
        logic          wr;
        logic [AW-1:0] waddr;
        logic [WW-1:0] wval;
        logic          cv;
        logic [WW-1:0] cval;
        logic          dv;
        logic [WW-1:0] dval;
        logic [3:0]    pend;
        logic          chk_dc;
        logic [1:0]    dc_i;
        logic [WW-1:0] dc_v;
    } vec_t;

    typedef struct {
        logic [1:0]    dest;
        logic [1:0]    idx;
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    logic [WW-1:0] mem [256];
    logic [WW-1:0] rd_pipe [L];
    pend_t         pend_q[$];
    logic [WW-1:0] exp_q[$];
    int            exp_due[$];
    logic [WW-1:0] exp_ds_q[$];
    int            exp_ds_due[$];
    logic [WW-1:0] exp_dc [4];
    int            cyc;
    int            n_checks;
    int            n_errors;

    // kind: 0 idle, 1 conveyor, 2 dstack, 3 reload, 4 reload+conveyor
    function automatic vec_t mk(input int kind, input logic [1:0] ch, input logic [AW-1:0] ra,
                                input logic wr, input logic [AW-1:0] wa, input logic [WW-1:0] wv,
                                input logic cv, input logic [WW-1:0] cval,
                                input logic dv, input logic [WW-1:0] dval,
                                input logic [3:0] pend, input logic chk_dc,
                                input logic [1:0] dc_i, input logic [WW-1:0] dc_v);
        vec_t v;
        v.reload = (kind == 3) || (kind == 4);
        v.conv   = (kind == 1) || (kind == 4);
        v.dstack = (kind == 2);
        v.choice = ch;     v.raddr = ra;
        v.wr     = wr;     v.waddr = wa;     v.wval = wv;
        v.cv     = cv;     v.cval  = cval;
        v.dv     = dv;     v.dval  = dval;
        v.pend   = pend;   v.chk_dc = chk_dc; v.dc_i = dc_i; v.dc_v = dc_v;
        return v;
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.reload           = v.reload;
        bus.choice           = v.choice;
        bus.dstack_memload   = v.dstack;
        bus.conveyor_memload = v.conv;
        bus.read_address     = v.raddr;
        bus.write_out        = v.wr;
        bus.write_address    = v.waddr;
        bus.write_value      = v.wval;
        bus.mem_read_value   = rd_pipe[L-1];
    endtask

    task automatic sb_check();
        logic [3:0] ep;
        logic       ev;
        logic [WW-1:0] val;
        ep = '0;
        foreach (pend_q[j]) if (pend_q[j].dest == D_DC) ep[pend_q[j].idx] = 1'b1;
        check("dc_pending", {28'd0, bus.dc_pending}, {28'd0, ep});
        for (int i = 0; i < 4; i++) check($sformatf("dc_vals[%0d]", i), bus.dc_vals[i], exp_dc[i]);
        ev = (exp_q.size() > 0) && (exp_due[0] == cyc);
        check("conveyor_valid", {31'd0, bus.conveyor_valid}, {31'd0, ev});
        if (ev) begin
            val = exp_q.pop_front();
            void'(exp_due.pop_front());
            if (bus.conveyor_valid) check("conveyor_value", bus.conveyor_value, val);
        end
        ev = (exp_ds_q.size() > 0) && (exp_ds_due[0] == cyc);
        check("dstack_valid", {31'd0, bus.dstack_valid}, {31'd0, ev});
        if (ev) begin
            val = exp_ds_q.pop_front();
            void'(exp_ds_due.pop_front());
            if (bus.dstack_valid) check("dstack_value", bus.dstack_value, val);
        end
    endtask

    // Memory returns its content at issue time; the block must deliver the
    // content as of the end of the return cycle.
    task automatic model_update(input vec_t v);
        logic  any;
        pend_t p;
        any = v.reload || v.dstack || v.conv;
        for (int k = L - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
        rd_pipe[0] = any ? mem[v.raddr[7:0]] : '0;
        if (any) begin
            p.addr = v.raddr;
            p.due  = cyc + L;
            p.idx  = v.choice;
            p.dest = v.reload ? D_DC : (v.dstack ? D_DSTACK : D_CONV);
            pend_q.push_back(p);
        end
        if (v.wr) mem[v.waddr[7:0]] = v.wval;
        for (int i = 0; i < 4; i++) if (v.wr && (v.waddr == bus.dcs[i])) exp_dc[i] = v.wval;
        while ((pend_q.size() > 0) && (pend_q[0].due == cyc)) begin
            p = pend_q.pop_front();
            case (p.dest)
                D_CONV:   begin exp_q.push_back(mem[p.addr[7:0]]);    exp_due.push_back(cyc + 1);    end
                D_DSTACK: begin exp_ds_q.push_back(mem[p.addr[7:0]]); exp_ds_due.push_back(cyc + 1); end
                default:  exp_dc[p.idx] = mem[p.addr[7:0]];
            endcase
        end
    endtask

    task automatic run_cycle(input vec_t v, input logic hand);
        drive(v);
        #1;
        sb_check();
        if (hand) begin
            check("tbl conveyor_valid", {31'd0, bus.conveyor_valid}, {31'd0, v.cv});
            if (v.cv) check("tbl conveyor_value", bus.conveyor_value, v.cval);
            check("tbl dstack_valid", {31'd0, bus.dstack_valid}, {31'd0, v.dv});
            if (v.dv) check("tbl dstack_value", bus.dstack_value, v.dval);
            check("tbl dc_pending", {28'd0, bus.dc_pending}, {28'd0, v.pend});
            if (v.chk_dc) check($sformatf("tbl dc_vals[%0d]", v.dc_i), bus.dc_vals[v.dc_i], v.dc_v);
        end
        model_update(v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t tbl[$];
    vec_t idle_v;
    vec_t rv;

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem['h10] = 32'hCAFEBABE;
        mem['h20] = 32'h11;
        mem['h21] = 32'h22;
        mem['h30] = 32'hAAAA;
        mem['h40] = 32'h1234;
        for (int k = 0; k < L; k++) rd_pipe[k] = '0;
        for (int i = 0; i < 4; i++) exp_dc[i] = '0;
        bus.dcs[0] = 16'h40;
        bus.dcs[1] = 16'h20;
        bus.dcs[2] = 16'h30;
        bus.dcs[3] = 16'h40;
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        drive(idle_v);

        // Directed vectors: one row per cycle, expected outputs as seen that cycle.
        tbl.push_back(mk(1, 0, 'h10, 0, 0, 0,          0, 0,            0, 0,     4'b0000, 0, 0, 0));
        tbl.push_back(idle_v);
        tbl.push_back(idle_v);
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          1, 32'hCAFEBABE, 0, 0,     4'b0000, 0, 0, 0));
        tbl.push_back(mk(3, 1, 'h20, 0, 0, 0,          0, 0,            0, 0,     4'b0000, 0, 0, 0));
        tbl.push_back(mk(2, 0, 'h21, 0, 0, 0,          0, 0,            0, 0,     4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 1, 32'h11));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            1, 32'h22, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(3, 2, 'h30, 0, 0, 0,          0, 0,            0, 0,     4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    1, 'h30, 32'h5555, 0, 0,           0, 0,     4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 2, 32'h5555));
        tbl.push_back(mk(4, 0, 'h40, 0, 0, 0,          0, 0,            0, 0,     4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 0, 32'h1234));
        tbl.push_back(idle_v);
        tbl.push_back(mk(0, 0, 0,    1, 'h40, 32'h77,  0, 0,            0, 0,     4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 3, 32'h77));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 0, 32'h77));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 1, 32'h11));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,          0, 0,            0, 0,     4'b0000, 1, 2, 32'h5555));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset conveyor_valid", {31'd0, bus.conveyor_valid}, 32'd0);
        check("reset dstack_valid", {31'd0, bus.dstack_valid}, 32'd0);
        check("reset conveyor_value", bus.conveyor_value, 32'd0);
        check("reset dstack_value", bus.dstack_value, 32'd0);
        check("reset dc_pending", {28'd0, bus.dc_pending}, 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("reset dc_vals[%0d]", i), bus.dc_vals[i], 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < tbl.size(); r++) run_cycle(tbl[r], 1'b1);

        // Three reads in flight, then a one-cycle reset.
        run_cycle(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0), 1'b0);
        run_cycle(mk(2, 0, 'h21, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0), 1'b0);
        run_cycle(mk(3, 3, 'h40, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0), 1'b0);
        drive(idle_v);
        reset = 1'b1;
        #1;
        check("midreset conveyor_valid", {31'd0, bus.conveyor_valid}, 32'd0);
        check("midreset dstack_valid", {31'd0, bus.dstack_valid}, 32'd0);
        check("midreset conveyor_value", bus.conveyor_value, 32'd0);
        check("midreset dstack_value", bus.dstack_value, 32'd0);
        check("midreset dc_pending", {28'd0, bus.dc_pending}, 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("midreset dc_vals[%0d]", i), bus.dc_vals[i], 32'd0);
        pend_q.delete();
        exp_q.delete();
        exp_due.delete();
        exp_ds_q.delete();
        exp_ds_due.delete();
        for (int i = 0; i < 4; i++) exp_dc[i] = '0;
        for (int k = L - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
        rd_pipe[0] = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        repeat (L + 4) run_cycle(idle_v, 1'b0);

        // Random traffic on a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            if ((n % 20) == 0) begin
                for (int i = 0; i < 4; i++) bus.dcs[i] = 16'($urandom_range(16, 23));
            end
            rv = mk($urandom_range(0, 4), 2'($urandom_range(0, 3)), 16'($urandom_range(16, 23)),
                    ($urandom_range(0, 9) < 4), 16'($urandom_range(16, 23)), $urandom,
                    0, 0, 0, 0, 4'b0000, 0, 0, 0);
            run_cycle(rv, 1'b0);
        end
        repeat (L + 3) run_cycle(idle_v, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
